// File: rtl/pwm_duty_controller_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pwm_duty_controller_pkg
// Shared definitions for the two-channel PWM duty controller:
//   - acc_state_e : state encoding of the shared threshold accumulator FSM
//   - LEVEL_W     : width of a duty level (drives a 4-bit seven-segment decoder)
//   - calc_step   : cycles per duty step (PERIOD / LEVELS)
//   - calc_cnt_w  : width of the period counter and all duty registers
//   - level_last  : highest legal level, i.e. the wrap point
//   - level_inc   : level + 1 with wrap from LEVELS-1 back to 0
// -----------------------------------------------------------------------------
package pwm_duty_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_WRITE = 2'd3
  } acc_state_e;

  localparam int LEVEL_W = 4;

  function automatic int calc_step(input int period, input int levels);
    return period / levels;
  endfunction

  function automatic int calc_cnt_w(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  function automatic logic [LEVEL_W-1:0] level_last(input int levels);
    return LEVEL_W'(levels - 1);
  endfunction

  // Anything at or beyond the last level wraps, so a corrupted level
  // recovers to 0 on the next press instead of running off the end.
  function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] level,
                                                   input int levels);
    logic [LEVEL_W-1:0] result;
    if (level >= level_last(levels)) begin
      result = '0;
    end else begin
      result = level + LEVEL_W'(1);
    end
    return result;
  endfunction

endpackage

// File: rtl/pwm_duty_controller_button_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// button_conditioner
// Turns one raw, asynchronous push button into a one-cycle press pulse.
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   btn_i    : raw button level, asynchronous to clk_i
//   press_o  : one-cycle pulse on each accepted rising edge
// Path: 2-FF synchroniser -> debounce counter -> rising-edge detect.
// The debounced state flips only after DEBOUNCE consecutive cycles in which
// the synchronised input differs from it; any agreeing cycle restarts the count.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE = 250_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic            stable_prev_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;

  // Synchroniser, debounce state and edge-detect history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      db_cnt_q      <= '0;
    end else begin
      sync1_q       <= btn_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      db_cnt_q      <= db_cnt_d;
    end
  end

  // Debounce: count the run of differing cycles, accept on the last one.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  assign press_o = stable_q & ~stable_prev_q;

endmodule

// File: rtl/pwm_duty_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pwm_duty_controller
// Two-channel PWM duty controller.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   btn[1:0] : raw push buttons, bit i advances channel i's level
//   pwm_out  : registered PWM outputs, high while cnt < active threshold
//   level0/1 : current 4-bit duty levels for the seven-segment decoders
//   busy     : high while the threshold accumulator is not idle
// Each press advances a channel's level 0..LEVELS-1 (wrapping) and marks the
// channel pending. A single shared accumulator, granted round-robin, turns
// the level into a threshold (level * STEP) by repeated addition and writes
// it to the channel's shadow register. Shadows move to the active registers
// only at a period wrap so a PWM period is never cut short.
// -----------------------------------------------------------------------------
module pwm_duty_controller
  import pwm_duty_controller_pkg::*;
#(
  parameter int PERIOD   = 2_000_000,
  parameter int LEVELS   = 10,
  parameter int DEBOUNCE = 250_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         btn,
  output logic [1:0]         pwm_out,
  output logic [LEVEL_W-1:0] level0,
  output logic [LEVEL_W-1:0] level1,
  output logic               busy
);

  localparam int STEP  = calc_step(PERIOD, LEVELS);
  localparam int CNT_W = calc_cnt_w(PERIOD);
  localparam logic [CNT_W-1:0] STEP_C      = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);

  logic [1:0]                    press_s;
  logic [1:0][LEVEL_W-1:0]       level_q;
  logic [1:0][LEVEL_W-1:0]       level_d;
  logic [1:0]                    pending_q;
  logic [1:0]                    pending_d;
  acc_state_e                    state_q;
  acc_state_e                    state_d;
  logic                          grant_q;
  logic                          grant_d;
  logic                          last_grant_q;
  logic                          last_grant_d;
  logic [CNT_W-1:0]              acc_q;
  logic [CNT_W-1:0]              acc_d;
  logic [LEVEL_W-1:0]            rem_q;
  logic [LEVEL_W-1:0]            rem_d;
  logic [1:0][CNT_W-1:0]         shadow_q;
  logic [1:0][CNT_W-1:0]         shadow_d;
  logic [1:0][CNT_W-1:0]         active_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          wrap_s;
  logic [1:0]                    pwm_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      button_conditioner #(
        .DEBOUNCE (DEBOUNCE)
      ) u_cond (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn[gi]),
        .press_o (press_s[gi])
      );
    end
  endgenerate

  // Level advance on each accepted press.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      if (press_s[i]) begin
        level_d[i] = level_inc(level_q[i], LEVELS);
      end else begin
        level_d[i] = level_q[i];
      end
    end
  end

  // Accumulator FSM: arbitration, repeated addition and shadow write.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q != 2'b00) begin
          // Both waiting: alternate away from the channel served last.
          if (pending_q == 2'b11) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = pending_q[1];
          end
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        acc_d              = '0;
        rem_d              = level_q[grant_q];
        pending_d[grant_q] = 1'b0;
        state_d            = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (rem_q != '0) begin
          acc_d = acc_q + STEP_C;
          rem_d = rem_q - LEVEL_W'(1);
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        shadow_d[grant_q] = acc_q;
        last_grant_d      = grant_q;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A press arriving while its channel is being loaded must not be lost.
    pending_d = pending_d | press_s;
  end

  // Levels, pending flags, FSM and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q      <= '0;
      pending_q    <= 2'b00;
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      acc_q        <= '0;
      rem_q        <= '0;
      shadow_q     <= '0;
    end else begin
      level_q      <= level_d;
      pending_q    <= pending_d;
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      shadow_q     <= shadow_d;
    end
  end

  assign wrap_s = (cnt_q == PERIOD_LAST);

  // Period counter, shadow-to-active transfer at wrap, PWM compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= '0;
      pwm_q    <= 2'b00;
    end else begin
      if (wrap_s) begin
        cnt_q    <= '0;
        active_q <= shadow_q;
      end else begin
        cnt_q    <= cnt_q + CNT_W'(1);
      end
      pwm_q[0] <= (cnt_q < active_q[0]);
      pwm_q[1] <= (cnt_q < active_q[1]);
    end
  end

  assign pwm_out = pwm_q;
  assign level0  = level_q[0];
  assign level1  = level_q[1];
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_duty_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pwm_duty_controller
// Scoreboarded bench for pwm_duty_controller with PERIOD=100, LEVELS=10,
// DEBOUNCE=4 (STEP=10). Expected levels are pushed when a press is driven and
// popped when the DUT's levels change; duties are measured over a 100-cycle
// window and compared with level*STEP from the bench's own level model.
// -----------------------------------------------------------------------------
module tb_pwm_duty_controller;
  import pwm_duty_controller_pkg::*;

  localparam int PERIOD   = 100;
  localparam int LEVELS   = 10;
  localparam int DEBOUNCE = 4;
  localparam int STEP     = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn = 2'b00;
  logic [1:0] pwm_out;
  logic [3:0] level0;
  logic [3:0] level1;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       grant_log[$];
  logic [3:0] m_l0 = 4'd0;
  logic [3:0] m_l1 = 4'd0;

  pwm_duty_controller #(
    .PERIOD   (PERIOD),
    .LEVELS   (LEVELS),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .pwm_out (pwm_out),
    .level0  (level0),
    .level1  (level1),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] next_lvl(input logic [3:0] l);
    return (l == 4'd9) ? 4'd0 : l + 4'd1;
  endfunction

  task automatic apply_reset();
    btn = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_l0 = 4'd0;
    m_l1 = 4'd0;
    exp_q.delete();
  endtask

  // Press the channels in mask; returns press-to-level latency and busy cycles.
  task automatic do_press(input logic [1:0] mask, input int settle, input bit track,
                          output int lat, output int busy_cnt);
    logic [7:0] prev;
    logic [7:0] got;
    logic [7:0] expv;
    logic       busy_prev;
    prev = {level1, level0};
    if (mask[0]) m_l0 = next_lvl(m_l0);
    if (mask[1]) m_l1 = next_lvl(m_l1);
    exp_q.push_back({m_l1, m_l0});
    @(negedge clk);
    btn = mask;
    lat = 0;
    while ({level1, level0} == prev && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got  = {level1, level0};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL press_level mask=%b got=%h expected=%h", mask, got, expv);
    end
    busy_cnt = 0;
    if (track) begin
      busy_prev = busy;
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (busy && !busy_prev) grant_log.push_back(dut.grant_q);
        busy_prev = busy;
      end
    end else begin
      repeat (3) @(negedge clk);
    end
    btn = 2'b00;
    repeat (settle) @(negedge clk);
  endtask

  task automatic measure(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (pwm_out[0]) h0++;
      if (pwm_out[1]) h1++;
    end
  endtask

  task automatic test_reset();
    int nz;
    apply_reset();
    checks++;
    if (pwm_out !== 2'b00) begin failures++; $display("FAIL reset_pwm got=%b expected=00", pwm_out); end
    checks++;
    if (level0 !== 4'd0) begin failures++; $display("FAIL reset_level0 got=%0d expected=0", level0); end
    checks++;
    if (level1 !== 4'd0) begin failures++; $display("FAIL reset_level1 got=%0d expected=0", level1); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
    nz = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pwm_out != 2'b00 || level0 != 4'd0 || level1 != 4'd0 || busy) nz++;
    end
    checks++;
    if (nz != 0) begin failures++; $display("FAIL reset_idle nonzero_cycles=%0d expected=0", nz); end
  endtask

  task automatic test_single_press();
    int lat, bc, h0, h1;
    do_press(2'b01, 10, 1'b1, lat, bc);
    checks++;
    if (lat != 7) begin failures++; $display("FAIL press_latency got=%0d expected=7", lat); end
    checks++;
    if (bc != 4) begin failures++; $display("FAIL busy_cycles got=%0d expected=4", bc); end
    repeat (110) @(negedge clk);
    measure(h0, h1);
    checks++;
    if (h0 != int'(m_l0) * STEP) begin failures++; $display("FAIL duty0_single got=%0d expected=%0d", h0, int'(m_l0) * STEP); end
    checks++;
    if (h1 != 0) begin failures++; $display("FAIL duty1_single got=%0d expected=0", h1); end
  endtask

  task automatic test_wrap_around();
    int lat, bc, h0, h1;
    for (int k = 1; k <= 10; k++) begin
      do_press(2'b10, 15, 1'b0, lat, bc);
      if (k == 9 || k == 10) begin
        repeat (110) @(negedge clk);
        measure(h0, h1);
        checks++;
        if (h1 != int'(m_l1) * STEP) begin
          failures++;
          $display("FAIL duty1_wrap press=%0d got=%0d expected=%0d", k, h1, int'(m_l1) * STEP);
        end
        checks++;
        if (h0 != int'(m_l0) * STEP) begin
          failures++;
          $display("FAIL duty0_hold press=%0d got=%0d expected=%0d", k, h0, int'(m_l0) * STEP);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] prev;
    logic [7:0] got;
    logic [7:0] expv;
    int lat, changes;
    prev = {level1, level0};
    m_l0 = next_lvl(m_l0);
    exp_q.push_back({m_l1, m_l0});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn[0] = ~btn[0];
      @(negedge clk);
    end
    @(negedge clk);
    btn[0] = 1'b1;
    lat = 0;
    while ({level1, level0} == prev && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got  = {level1, level0};
    expv = exp_q.pop_front();
    checks++;
    if (got !== expv) begin failures++; $display("FAIL bounce_level got=%h expected=%h", got, expv); end
    changes = 0;
    prev = {level1, level0};
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({level1, level0} != prev) changes++;
      prev = {level1, level0};
    end
    checks++;
    if (changes != 0) begin failures++; $display("FAIL bounce_extra changes=%0d expected=0", changes); end
    btn = 2'b00;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bc, n;
    apply_reset();
    grant_log.delete();
    do_press(2'b11, 0, 1'b1, lat, bc);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] !== 1'b0 || grant_log[1] !== 1'b1) begin
      failures++;
      $display("FAIL rr_order grants=%0d first=%b second=%b expected 2 grants 0 then 1",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 1'bx,
               (grant_log.size() > 1) ? grant_log[1] : 1'bx);
    end
    checks++;
    if (bc != 8) begin failures++; $display("FAIL rr_busy_cycles got=%0d expected=8", bc); end
    checks++;
    if (dut.shadow_q[0] !== 7'(STEP)) begin failures++; $display("FAIL shadow0 got=%0d expected=%0d", dut.shadow_q[0], STEP); end
    checks++;
    if (dut.shadow_q[1] !== 7'(STEP)) begin failures++; $display("FAIL shadow1 got=%0d expected=%0d", dut.shadow_q[1], STEP); end
    n = 0;
    while (pwm_out == 2'b00 && n < 250) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pwm_out !== 2'b11) begin failures++; $display("FAIL same_wrap got=%b expected=11", pwm_out); end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bc, h0, h1;
    apply_reset();
    for (int k = 1; k <= 8; k++) do_press(2'b01, 15, 1'b0, lat, bc);
    do_press(2'b01, 0, 1'b0, lat, bc);
    checks++;
    if (dut.state_q !== ST_ACCUM || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_precond state=%0d busy=%b expected ACCUM busy=1", dut.state_q, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_l0 = 4'd0;
    m_l1 = 4'd0;
    checks++;
    if (dut.state_q !== ST_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_idle state=%0d busy=%b expected IDLE busy=0", dut.state_q, busy);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (dut.shadow_q !== '0 || dut.active_q !== '0) begin
      failures++;
      $display("FAIL mid_nowrite shadow=%h active=%h expected 0", dut.shadow_q, dut.active_q);
    end
    checks++;
    if (level0 !== 4'd0 || level1 !== 4'd0 || pwm_out !== 2'b00) begin
      failures++;
      $display("FAIL mid_outputs l0=%0d l1=%0d pwm=%b expected 0", level0, level1, pwm_out);
    end
    do_press(2'b01, 15, 1'b0, lat, bc);
    repeat (110) @(negedge clk);
    measure(h0, h1);
    checks++;
    if (h0 != int'(m_l0) * STEP) begin failures++; $display("FAIL mid_recover_duty got=%0d expected=%0d", h0, int'(m_l0) * STEP); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_wrap_around();
    test_bounce();
    test_back_to_back();
    test_reset_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
